count_pwm: RTL and testbench

COUNT_PWM -- requirements
Module: count_pwm

---
 rtl/count_pwm_pkg.sv | 15 +
 rtl/count_tracker.sv | 31 +++
 rtl/count_pwm.sv | 112 +++++++++++
 tb/tb_count_pwm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_pwm_pkg.sv
// Shared types and defaults for the count-synchronised PWM block.
// Holds the FSM state encoding and the default counter widths.
package count_pwm_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int PCNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/count_tracker.sv
// Follows the upstream free-running count: remembers the previous value,
// flags the wrap to zero and any step that is neither hold nor +1.
module count_tracker
  import count_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  output logic             wrap,
  output logic             jump
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= '0;
    else       prev <= count_in;
  end

  always_comb begin
    wrap = (prev == CMAX) && (count_in == '0);
    jump = !wrap
        && (count_in != prev)
        && (count_in != prev + CNT_W'(1));
  end

endmodule

// File: rtl/count_pwm.sv
// PWM generator locked to an external up-counter; duty changes only
// take effect at a count wrap so every period is glitch-free.
module count_pwm
  import count_pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PCNT_W = PCNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              en,
  input  logic              duty_valid,
  input  logic [CNT_W:0]    duty,
  output logic              duty_ready,
  input  logic              clr,
  output logic              pwm_out,
  output logic              period_done,
  output logic [PCNT_W-1:0] period_cnt,
  output logic              sync_err
);

  localparam logic [CNT_W:0]    DMAX = {1'b1, {CNT_W{1'b0}}};
  localparam logic [PCNT_W-1:0] PMAX = '1;

  state_t         state;
  state_t         next_state;
  logic           wrap;
  logic           jump;
  logic           pending;
  logic [CNT_W:0] duty_pend;
  logic [CNT_W:0] duty_active;
  logic [CNT_W:0] duty_eff;
  logic [CNT_W:0] duty_clamp;
  logic           hs;
  logic           load;
  logic           running;
  logic           next_running;

  count_tracker #(.CNT_W(CNT_W)) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .wrap     (wrap),
    .jump     (jump)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (en) next_state = ARM;
      ARM:   if (!en) next_state = IDLE;
             else if (wrap) next_state = RUN;
      RUN:   if (!en) next_state = DRAIN;
      DRAIN: if (en) next_state = RUN;
             else if (wrap) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    duty_ready   = !pending;
    hs           = duty_valid && !pending;
    load         = wrap && pending;
    duty_clamp   = (duty > DMAX) ? DMAX : duty;
    duty_eff     = load ? duty_pend : duty_active;
    running      = (state == RUN) || (state == DRAIN);
    next_running = (next_state == RUN) || (next_state == DRAIN);
  end

  // A handshake needs pending clear, so it never collides with a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= 1'b0;
      duty_pend   <= '0;
      duty_active <= '0;
    end else if (load) begin
      pending     <= 1'b0;
      duty_active <= duty_pend;
    end else if (hs) begin
      pending     <= 1'b1;
      duty_pend   <= duty_clamp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
      period_cnt  <= '0;
      sync_err    <= 1'b0;
    end else begin
      pwm_out     <= next_running && ({1'b0, count_in} < duty_eff);
      period_done <= wrap && running;
      if (clr) begin
        period_cnt <= '0;
        sync_err   <= 1'b0;
      end else begin
        if (wrap && running && period_cnt != PMAX)
          period_cnt <= period_cnt + PCNT_W'(1);
        if (jump)
          sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_count_pwm.sv
// Directed bench for count_pwm: drives the upstream count by hand and
// checks PWM shape, duty handover, drain, sync errors and saturation.
module tb_count_pwm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count_in;
  logic       en;
  logic       duty_valid;
  logic [4:0] duty;
  logic       duty_ready;
  logic       clr;
  logic       pwm_out;
  logic       period_done;
  logic [7:0] period_cnt;
  logic       sync_err;

  int n_chk = 0;
  int n_err = 0;

  count_pwm #(.CNT_W(4), .PCNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .en          (en),
    .duty_valid  (duty_valid),
    .duty        (duty),
    .duty_ready  (duty_ready),
    .clr         (clr),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .period_cnt  (period_cnt),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d want %0d", tag, $time, got, exp);
    end
  endtask

  task automatic step(input int c);
    count_in = 4'(c);
    @(posedge clk);
    #1;
  endtask

  // counts lo..hi without a wrap; pwm follows count < d
  task automatic seg(input int lo, input int hi, input int d);
    for (int c = lo; c <= hi; c++) begin
      step(c);
      chk("pwm", int'(pwm_out), int'(c < d));
      chk("done_lo", int'(period_done), 0);
    end
  endtask

  task automatic wrap_step(input int d, input int done);
    step(0);
    chk("pwm_wrap", int'(pwm_out), int'(0 < d));
    chk("done_wrap", int'(period_done), done);
  endtask

  initial begin
    reset = 1'b1;
    count_in = '0;
    en = 1'b0;
    duty_valid = 1'b0;
    duty = '0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ready", int'(duty_ready), 1);
    chk("rst_done", int'(period_done), 0);
    chk("rst_cnt", int'(period_cnt), 0);
    chk("rst_err", int'(sync_err), 0);
    reset = 1'b0;

    // duty 5 accepted in IDLE, armed, runs from first wrap
    en = 1'b1;
    duty_valid = 1'b1;
    duty = 5'd5;
    step(0);
    duty_valid = 1'b0;
    chk("pend_ready", int'(duty_ready), 0);
    seg(1, 15, 0);
    wrap_step(5, 0);
    chk("load_ready", int'(duty_ready), 1);
    seg(1, 15, 5);
    wrap_step(5, 1);
    chk("cnt1", int'(period_cnt), 1);
    seg(1, 15, 5);
    wrap_step(5, 1);
    chk("cnt2", int'(period_cnt), 2);

    // duty 12 offered mid-period, applies at wrap
    seg(1, 6, 5);
    duty_valid = 1'b1;
    duty = 5'd12;
    seg(7, 7, 5);
    duty_valid = 1'b0;
    chk("mid_ready", int'(duty_ready), 0);
    seg(8, 15, 5);
    chk("late_ready", int'(duty_ready), 0);
    wrap_step(12, 1);
    chk("ready_back", int'(duty_ready), 1);
    chk("cnt3", int'(period_cnt), 3);
    // offer in a wrap cycle waits one more period
    seg(1, 15, 12);
    duty_valid = 1'b1;
    duty = 5'd3;
    wrap_step(12, 1);
    duty_valid = 1'b0;
    chk("wrap_pend", int'(duty_ready), 0);
    seg(1, 15, 12);
    wrap_step(3, 1);
    chk("cnt5", int'(period_cnt), 5);

    // drain after en drop, then idle
    seg(1, 2, 3);
    en = 1'b0;
    seg(3, 15, 3);
    wrap_step(0, 1);
    chk("cnt6", int'(period_cnt), 6);
    seg(1, 15, 0);
    wrap_step(0, 0);
    // re-arm, then recover from DRAIN with no gap
    en = 1'b1;
    seg(1, 15, 0);
    wrap_step(3, 0);
    seg(1, 2, 3);
    en = 1'b0;
    seg(3, 8, 3);
    en = 1'b1;
    seg(9, 15, 3);
    wrap_step(3, 1);
    chk("cnt7", int'(period_cnt), 7);

    // upstream jump 7 -> 0 is an error, not a wrap
    seg(1, 7, 3);
    step(0);
    chk("jump_pwm", int'(pwm_out), 1);
    chk("jump_done", int'(period_done), 0);
    chk("jump_err", int'(sync_err), 1);
    chk("jump_cnt", int'(period_cnt), 7);
    seg(1, 15, 3);
    wrap_step(3, 1);
    chk("cnt8", int'(period_cnt), 8);
    chk("err_sticky", int'(sync_err), 1);
    clr = 1'b1;
    seg(1, 1, 3);
    clr = 1'b0;
    chk("clr_err", int'(sync_err), 0);
    chk("clr_cnt", int'(period_cnt), 0);

    // clamp 20 -> 16 gives constant high, 0 gives constant low
    duty_valid = 1'b1;
    duty = 5'd20;
    seg(2, 2, 3);
    duty_valid = 1'b0;
    seg(3, 15, 3);
    wrap_step(16, 1);
    duty_valid = 1'b1;
    duty = 5'd0;
    seg(1, 1, 16);
    duty_valid = 1'b0;
    seg(2, 15, 16);
    wrap_step(0, 1);
    seg(1, 15, 0);
    wrap_step(0, 1);
    chk("cnt_c3", int'(period_cnt), 3);

    // saturation
    for (int p = 0; p < 300; p++)
      for (int c = 1; c <= 16; c++)
        step(c % 16);
    chk("sat", int'(period_cnt), 255);
    seg(1, 15, 0);
    wrap_step(0, 1);
    chk("sat_hold", int'(period_cnt), 255);

    // async reset mid-period with a duty pending
    duty_valid = 1'b1;
    duty = 5'd16;
    seg(1, 1, 0);
    duty_valid = 1'b0;
    seg(2, 15, 0);
    wrap_step(16, 1);
    duty_valid = 1'b1;
    duty = 5'd8;
    seg(1, 1, 16);
    duty_valid = 1'b0;
    seg(2, 9, 16);
    chk("pre_rst_ready", int'(duty_ready), 0);
    count_in = 4'd10;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pwm", int'(pwm_out), 0);
    chk("arst_ready", int'(duty_ready), 1);
    chk("arst_done", int'(period_done), 0);
    chk("arst_cnt", int'(period_cnt), 0);
    chk("arst_err", int'(sync_err), 0);
    count_in = 4'd0;
    en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post_done", int'(period_done), 0);
    // discarded duty must not reappear
    en = 1'b1;
    seg(1, 15, 0);
    wrap_step(0, 0);
    seg(1, 15, 0);
    wrap_step(0, 1);
    chk("post_cnt", int'(period_cnt), 1);
    chk("post_err", int'(sync_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
